ntt_ctrl_fsm: RTL
=================

NTT_CTRL_FSM -- requirements
Module: ntt_ctrl_fsm

Interface
REQ-001 Parameter DEPTH, default 8, log2 of polynomial length N; per-layer butterfly count is 2^(DEPTH-1).
REQ-002 Parameter LAYERS, default 7, number of butterfly layers per transform; range 1..15.
REQ-003 Parameter PIPE_LAT, default 5, butterfly pipeline latency in cycles; range 1..2^(DEPTH-1)-1.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  begin a transform; sampled only in IDLE.
REQ-007 mode  input  1  0 = forward NTT (CT), 1 = inverse NTT (GS); latched on accepted start.
REQ-008 full_in  input  1  input RAM load complete.
REQ-009 cal_en  input  1  permission to begin computing.
REQ-010 full_out  input  1  result fully read out.
REQ-011 stall  input  1  freeze compute progress (see Configuration).
REQ-012 rd_ctrl, wr_ctrl  output  1 each  butterfly read-issue / write-back enables.
REQ-013 ram1_we, ram2_we  output  1 each  ping-pong RAM write enables.
REQ-014 layer_type  output  1  equals bit 0 of the 1-based layer count.
REQ-015 layer_idx  output  4  twiddle layer index.
REQ-016 bf_mode  output  1  latched mode.
REQ-017 res_sel  output  1  constant LAYERS[0]; 1 = result in RAM2.
REQ-018 readin_ok, busy, done  output  1 each  load window / transform active / result ready.

Function
REQ-019 States SHALL be IDLE, LOAD, WAIT_CAL, PRIME, STREAM, DRAIN, LAYER_END, UNLOAD; all outputs SHALL be Moore-decoded from the state register and counters.
REQ-020 IDLE: start=1 -> LOAD, mode latched; otherwise stay; readin_ok=0, busy=0, done=0.
REQ-021 LOAD: readin_ok=1, ram1_we=1; full_in=1 -> WAIT_CAL.
REQ-022 WAIT_CAL: readin_ok=0, busy=1; cal_en=1 -> PRIME with layer count=1 and bf counter=0.
REQ-023 PRIME: rd_ctrl=1, wr_ctrl=0, ram1_we=ram2_we=0; lasts exactly PIPE_LAT cycles -> STREAM.
REQ-024 STREAM: rd_ctrl=wr_ctrl=1; lasts exactly 2^(DEPTH-1)-PIPE_LAT cycles -> DRAIN.
REQ-025 DRAIN: rd_ctrl=0, wr_ctrl=1; lasts exactly PIPE_LAT cycles -> LAYER_END.
REQ-026 In STREAM and DRAIN: odd layer -> ram2_we=1, ram1_we=0; even layer -> ram1_we=1, ram2_we=0.
REQ-027 LAYER_END: one cycle, rd/wr/we all 0, layer count increments; count equal to LAYERS -> UNLOAD, else -> PRIME.
REQ-028 Per-layer compute length SHALL be 2^(DEPTH-1)+PIPE_LAT+1 cycles (134 at defaults).
REQ-029 layer_idx SHALL be count-1 when bf_mode=0 and LAYERS-count when bf_mode=1.
REQ-030 UNLOAD: done=1, busy=0, we=0; full_out=1 -> IDLE.
REQ-031 start outside IDLE SHALL be ignored; mode changes after acceptance SHALL have no effect.
REQ-032 full_in in WAIT_CAL, cal_en outside WAIT_CAL, and full_out outside UNLOAD SHALL be ignored.
REQ-033 Illegal state encodings SHALL recover to IDLE on the next clock.

Reset
REQ-034 reset_n=0 SHALL immediately force IDLE, counters 0, layer count 1, bf_mode 0, and every output except res_sel to 0.
REQ-035 Reset asserted mid-transform SHALL abort it; no write enable may assert until a new start is accepted.

Configuration
REQ-036 With NTT_CTRL_STALL_EN defined, stall=1 in PRIME/STREAM/DRAIN/LAYER_END SHALL hold the state and counters and force rd_ctrl, wr_ctrl, ram1_we and ram2_we to 0; outside those states stall SHALL have no effect.
REQ-037 Without NTT_CTRL_STALL_EN, stall SHALL be ignored and no stall logic synthesised.

Verification
REQ-038 Defaults, mode=0, start, full_in, cal_en -> 7 layers of 134 cycles each (938 total), layer_idx 0..6, done=1, res_sel=1.
REQ-039 mode=1 -> layer_idx 6..0, bf_mode=1; layer 1 asserts ram2_we for exactly 128 cycles, layer 2 asserts ram1_we for exactly 128 cycles.
REQ-040 DEPTH=4, PIPE_LAT=2, LAYERS=2 -> per layer rd_ctrl high 8 cycles and wr_ctrl high 8 cycles, 11-cycle layers, res_sel=0.
REQ-041 reset_n low during STREAM of layer 3 -> all outputs 0 immediately; a new start runs a full correct transform.
REQ-042 start pulsed during STREAM and full_out pulsed in WAIT_CAL -> no state change.
REQ-043 NTT_CTRL_STALL_EN, stall high 10 cycles in STREAM -> rd/wr/we low for those 10 cycles, layer lengthened by exactly 10 cycles.

Source files
------------

// File: rtl/ntt_ctrl_fsm.sv
// ntt_ctrl_fsm: sequencing controller for an in-place ping-pong NTT engine.
// Each transform runs through load, permission wait, LAYERS butterfly layers
// (prime / stream / drain / layer end), and unload. Layer results alternate
// between RAM2 (odd layers) and RAM1 (even layers).
// Optional feature: define NTT_CTRL_STALL_EN to let `stall` freeze compute
// progress. Without the macro, `stall` is ignored and adds no logic.
// Handshakes are level-based: start, full_in, cal_en and full_out are only
// acted on in the state that waits for them (IDLE, LOAD, WAIT_CAL, UNLOAD
// respectively). Other states ignore them.
module ntt_ctrl_fsm #(
    parameter int DEPTH    = 8,
    parameter int LAYERS   = 7,
    parameter int PIPE_LAT = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       mode,
    input  logic       full_in,
    input  logic       cal_en,
    input  logic       full_out,
    input  logic       stall,
    output logic       rd_ctrl,
    output logic       wr_ctrl,
    output logic       ram1_we,
    output logic       ram2_we,
    output logic       layer_type,
    output logic [3:0] layer_idx,
    output logic       bf_mode,
    output logic       res_sel,
    output logic       readin_ok,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    localparam int             HALF        = 1 << (DEPTH - 1);
    localparam int             CW          = DEPTH;
    localparam logic [CW-1:0]  PRIME_LAST  = CW'(PIPE_LAT - 1);
    localparam logic [CW-1:0]  STREAM_LAST = CW'(HALF - PIPE_LAT - 1);
    localparam logic [3:0]     LAYERS_L    = 4'(LAYERS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_CAL  = 3'd2,
        PRIME     = 3'd3,
        STREAM    = 3'd4,
        DRAIN     = 3'd5,
        LAYER_END = 3'd6,
        UNLOAD    = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      layer_q, layer_d;
    logic            bf_mode_q, bf_mode_d;
    logic            compute;
    logic            stall_hold;

    assign compute = (state_q == PRIME) || (state_q == STREAM) ||
                     (state_q == DRAIN) || (state_q == LAYER_END);

`ifdef NTT_CTRL_STALL_EN
    // Stall only freezes the compute phases; elsewhere it is a no-op.
    assign stall_hold = stall && compute;
`else
    logic unused_stall;
    assign stall_hold   = 1'b0;
    assign unused_stall = stall;
`endif

    // State, counters and latched mode; async reset aborts any transform.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            layer_q   <= 4'd1;
            bf_mode_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            layer_q   <= layer_d;
            bf_mode_q <= bf_mode_d;
        end
    end

    // Next-state and counter sequencing; a stall holds everything in place.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        layer_d   = layer_q;
        bf_mode_d = bf_mode_q;
        if (!stall_hold) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = LOAD;
                        bf_mode_d = mode;
                    end
                end
                LOAD: begin
                    if (full_in) state_d = WAIT_CAL;
                end
                WAIT_CAL: begin
                    if (cal_en) begin
                        state_d = PRIME;
                        layer_d = 4'd1;
                        cnt_d   = '0;
                    end
                end
                PRIME: begin
                    if (cnt_q == PRIME_LAST) begin
                        state_d = STREAM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STREAM: begin
                    if (cnt_q == STREAM_LAST) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt_q == PRIME_LAST) begin
                        state_d = LAYER_END;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                LAYER_END: begin
                    cnt_d = '0;
                    if (layer_q == LAYERS_L) begin
                        state_d = UNLOAD;
                    end else begin
                        state_d = PRIME;
                        layer_d = layer_q + 4'd1;
                    end
                end
                UNLOAD: begin
                    if (full_out) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Moore output decode from state, layer count and latched mode.
    always_comb begin
        rd_ctrl    = 1'b0;
        wr_ctrl    = 1'b0;
        ram1_we    = 1'b0;
        ram2_we    = 1'b0;
        layer_type = 1'b0;
        layer_idx  = 4'd0;
        readin_ok  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            LOAD: begin
                readin_ok = 1'b1;
                ram1_we   = 1'b1;
            end
            WAIT_CAL: busy = 1'b1;
            PRIME: begin
                busy    = 1'b1;
                rd_ctrl = 1'b1;
            end
            STREAM: begin
                busy    = 1'b1;
                rd_ctrl = 1'b1;
                wr_ctrl = 1'b1;
                ram2_we = layer_q[0];
                ram1_we = ~layer_q[0];
            end
            DRAIN: begin
                busy    = 1'b1;
                wr_ctrl = 1'b1;
                ram2_we = layer_q[0];
                ram1_we = ~layer_q[0];
            end
            LAYER_END: busy = 1'b1;
            UNLOAD:    done = 1'b1;
            default: ;
        endcase
        if (compute) begin
            layer_type = layer_q[0];
            layer_idx  = bf_mode_q ? (LAYERS_L - layer_q) : (layer_q - 4'd1);
        end
        if (stall_hold) begin
            rd_ctrl = 1'b0;
            wr_ctrl = 1'b0;
            ram1_we = 1'b0;
            ram2_we = 1'b0;
        end
    end

    assign bf_mode   = bf_mode_q;
    assign res_sel   = LAYERS_L[0];
    assign state_dbg = state_q;

endmodule
